// File: rtl/tcdm_bank_responder.sv
// Single-port TCDM memory bank shared by MP masters. Round-robin grants are combinational,
// and each granted access is answered after exactly one cycle.
module tcdm_bank_responder #(
    parameter int unsigned MP        = 2,
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [MP-1:0]       tcdm_req,
    output logic [MP-1:0]       tcdm_gnt,
    input  logic [MP-1:0][31:0] tcdm_add,
    input  logic [MP-1:0]       tcdm_wen,
    input  logic [MP-1:0][3:0]  tcdm_be,
    input  logic [MP-1:0][31:0] tcdm_data,
    output logic [MP-1:0][31:0] tcdm_r_data,
    output logic [MP-1:0]       tcdm_r_valid,
    output logic                err_o,
    output logic [31:0]         err_addr_o
);
    localparam int unsigned PW = (MP > 1) ? $clog2(MP) : 1;
    localparam int unsigned CW = PW + 1;
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cand;
    logic [PW-1:0] win_idx;
    logic          win_vld;
    logic          grant;
    logic [31:0]   sel_add, sel_data;
    logic [3:0]    sel_be;
    logic          sel_wen;
    logic [32:0]   offs;
    logic          in_range;
    logic [AW-1:0] word_idx;
    logic          unused_lsb;
    logic [MP-1:0] rvalid_q;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q;
    logic [31:0]   err_addr_q;
    logic [31:0]   mem_q [DEPTH];

    // Scan ports starting at the pointer, wrapping modulo MP.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int unsigned i = 0; i < MP; i++) begin
            cand = {1'b0, ptr_q} + CW'(i);
            if (cand >= CW'(MP)) begin
                cand = cand - CW'(MP);
            end
            if (!win_vld && tcdm_req[cand[PW-1:0]]) begin
                win_vld = 1'b1;
                win_idx = cand[PW-1:0];
            end
        end
    end

    assign grant = win_vld && !rst_i;
    assign ptr_d = (win_idx == PW'(MP - 1)) ? '0 : win_idx + PW'(1);

    always_comb begin
        tcdm_gnt = '0;
        if (grant) begin
            tcdm_gnt[win_idx] = 1'b1;
        end
    end

    assign sel_add  = tcdm_add[win_idx];
    assign sel_data = tcdm_data[win_idx];
    assign sel_be   = tcdm_be[win_idx];
    assign sel_wen  = tcdm_wen[win_idx];

    // 33-bit difference so an address below the base shows up as a borrow.
    assign offs       = {1'b0, sel_add} - {1'b0, BASE_ADDR};
    assign in_range   = !offs[32] && ({2'b00, offs[31:2]} < DEPTH);
    assign word_idx   = offs[AW+1:2];
    assign unused_lsb = ^offs[1:0];

    assign rdata_d = (grant && sel_wen && in_range) ? mem_q[word_idx] : 32'h0;

    always_ff @(posedge clk_i) begin
        if (grant && !sel_wen && in_range) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (sel_be[b]) begin
                    mem_q[word_idx][8*b +: 8] <= sel_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q      <= '0;
            rvalid_q   <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            rvalid_q <= tcdm_gnt;
            rdata_q  <= rdata_d;
            if (grant) begin
                ptr_q <= ptr_d;
            end
            if (grant && !in_range) begin
                err_q <= 1'b1;
                if (!err_q) begin
                    err_addr_q <= sel_add;
                end
            end
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < MP; k++) begin
            tcdm_r_data[k] = rvalid_q[k] ? rdata_q : 32'h0;
        end
    end

    assign tcdm_r_valid = rvalid_q;
    assign err_o        = err_q;
    assign err_addr_o   = err_addr_q;

endmodule

// File: tb/tb_tcdm_bank_responder.sv
// Randomized and directed bench for tcdm_bank_responder against a word-array reference
// model with round-robin arbitration computed modulo MP.
module tb_tcdm_bank_responder;
    localparam int unsigned MP    = 2;
    localparam int unsigned DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0000_1000;

    logic                clk = 1'b0;
    logic                rst;
    logic [MP-1:0]       req, gnt, wen, r_valid;
    logic [MP-1:0][31:0] add, wdata, r_data;
    logic [MP-1:0][3:0]  be;
    logic                err;
    logic [31:0]         err_addr;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state
    int            ptr_m;
    logic [31:0]   mem_m   [DEPTH];
    logic [31:0]   known_m [DEPTH];
    bit            err_m;
    logic [31:0]   err_addr_m;
    logic [MP-1:0] exp_rv;
    logic [31:0]   exp_rd, exp_mask;

    tcdm_bank_responder #(
        .MP       (MP),
        .DEPTH    (DEPTH),
        .BASE_ADDR(BASE)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .tcdm_req    (req),
        .tcdm_gnt    (gnt),
        .tcdm_add    (add),
        .tcdm_wen    (wen),
        .tcdm_be     (be),
        .tcdm_data   (wdata),
        .tcdm_r_data (r_data),
        .tcdm_r_valid(r_valid),
        .err_o       (err),
        .err_addr_o  (err_addr)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input int p, input bit rq, input bit rd, input logic [31:0] ad,
                         input logic [3:0] b, input logic [31:0] d);
        req[p]   = rq;
        wen[p]   = rd;
        add[p]   = ad;
        be[p]    = b;
        wdata[p] = d;
    endtask

    task automatic idle();
        req   = '0;
        wen   = '1;
        add   = '0;
        be    = '0;
        wdata = '0;
    endtask

    task automatic model_reset();
        ptr_m      = 0;
        err_m      = 1'b0;
        err_addr_m = '0;
        exp_rv     = '0;
    endtask

    // Mid-cycle: check the grant and advance the model as if the coming edge grants it.
    task automatic arb_check();
        int     w;
        int     idx;
        longint a;
        @(negedge clk);
        w = -1;
        for (int i = 0; i < MP; i++) begin
            if (w < 0 && req[(ptr_m + i) % MP]) w = (ptr_m + i) % MP;
        end
        for (int k = 0; k < MP; k++) begin
            check_val($sformatf("gnt[%0d]", k), 32'(gnt[k]), 32'(w == k));
        end
        exp_rv   = '0;
        exp_rd   = '0;
        exp_mask = '1;
        if (w >= 0) begin
            exp_rv[w] = 1'b1;
            a = longint'({32'h0, add[w]});
            if (a >= longint'({32'h0, BASE}) && a < longint'({32'h0, BASE}) + 4 * DEPTH) begin
                idx = int'((a - longint'({32'h0, BASE})) / 4);
                if (wen[w]) begin
                    exp_rd   = mem_m[idx];
                    exp_mask = known_m[idx];
                end else begin
                    for (int b = 0; b < 4; b++) begin
                        if (be[w][b]) begin
                            mem_m[idx][8*b +: 8]   = wdata[w][8*b +: 8];
                            known_m[idx][8*b +: 8] = 8'hFF;
                        end
                    end
                end
            end else begin
                if (!err_m) err_addr_m = add[w];
                err_m = 1'b1;
            end
            ptr_m = (w + 1) % MP;
        end
    endtask

    task automatic rsp_check();
        @(posedge clk);
        #1;
        for (int k = 0; k < MP; k++) begin
            check_val($sformatf("r_valid[%0d]", k), 32'(r_valid[k]), 32'(exp_rv[k]));
            check_val($sformatf("r_data[%0d]", k), r_data[k] & (exp_rv[k] ? exp_mask : 32'hFFFF_FFFF),
                      exp_rv[k] ? (exp_rd & exp_mask) : 32'h0);
        end
        check_val("err_o", 32'(err), 32'(err_m));
        check_val("err_addr_o", err_addr, err_addr_m);
    endtask

    task automatic step();
        arb_check();
        rsp_check();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_gnt"}, 32'(gnt), 32'h0);
        check_val({tag, "_r_valid"}, 32'(r_valid), 32'h0);
        check_val({tag, "_r_data0"}, r_data[0], 32'h0);
        check_val({tag, "_r_data1"}, r_data[1], 32'h0);
        check_val({tag, "_err"}, 32'(err), 32'h0);
        check_val({tag, "_err_addr"}, err_addr, 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int unsigned r;
        for (int i = 0; i < DEPTH; i++) begin
            mem_m[i]   = '0;
            known_m[i] = '0;
        end
        model_reset();
        rst = 1'b1;
        idle();
        req = '1;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        // Contention from reset: both ports write continuously, expect grants 0,1,0,1
        for (int c = 0; c < 4; c++) begin
            drive(0, 1'b1, 1'b0, BASE + 32'h0, 4'hF, 32'hA000_0000 + 32'(c));
            drive(1, 1'b1, 1'b0, BASE + 32'h4, 4'hF, 32'hB000_0000 + 32'(c));
            step();
        end

        // Single write then read
        idle();
        drive(0, 1'b1, 1'b0, BASE + 32'h8, 4'hF, 32'hCAFE_BABE);
        step();
        drive(0, 1'b1, 1'b1, BASE + 32'h8, 4'h0, 32'h0);
        step();
        check_val("rd_cafebabe", r_data[0], 32'hCAFE_BABE);

        // Byte enables, including an all-zero mask that must not modify the word
        drive(0, 1'b1, 1'b0, BASE + 32'hC, 4'hF, 32'h1122_3344);
        step();
        drive(0, 1'b1, 1'b0, BASE + 32'hC, 4'b0101, 32'hAABB_CCDD);
        step();
        drive(0, 1'b1, 1'b1, BASE + 32'hC, 4'h0, 32'h0);
        step();
        check_val("rd_be0101", r_data[0], 32'h11BB_33DD);
        drive(0, 1'b1, 1'b0, BASE + 32'hC, 4'h0, 32'hFFFF_FFFF);
        step();
        drive(0, 1'b1, 1'b1, BASE + 32'hD, 4'h0, 32'h0);
        step();
        check_val("rd_be0000", r_data[0], 32'h11BB_33DD);

        // Out-of-range just past the top; only the first address is captured
        drive(0, 1'b1, 1'b1, BASE + 32'(4 * DEPTH), 4'h0, 32'h0);
        step();
        drive(0, 1'b1, 1'b1, BASE + 32'(4 * DEPTH) + 32'h4, 4'h0, 32'h0);
        step();
        check_val("oob_err", 32'(err), 32'h1);
        check_val("oob_err_addr", err_addr, BASE + 32'(4 * DEPTH));

        // Streaming on port 1: eight writes, then eight back-to-back reads
        idle();
        for (int i = 0; i < 8; i++) begin
            drive(1, 1'b1, 1'b0, BASE + 32'h40 + 32'(4 * i), 4'hF, 32'h5500_0000 + 32'(i * 17));
            step();
        end
        for (int i = 0; i < 8; i++) begin
            drive(1, 1'b1, 1'b1, BASE + 32'h40 + 32'(4 * i), 4'h0, 32'h0);
            step();
        end

        // Reset in the cycle after a read grant to port 0
        idle();
        drive(0, 1'b1, 1'b1, BASE + 32'h8, 4'h0, 32'h0);
        arb_check();
        @(posedge clk);
        #1 rst = 1'b1;
        req = '1;
        #1;
        check_reset_outputs("midrst");
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        drive(0, 1'b1, 1'b0, BASE + 32'h10, 4'hF, 32'h0123_4567);
        drive(1, 1'b1, 1'b0, BASE + 32'h14, 4'hF, 32'h89AB_CDEF);
        step();
        idle();
        step();

        // Randomized traffic, including occasional out-of-range addresses on both sides
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < MP; p++) begin
                r = $urandom_range(0, 19);
                if (r == 0) a = BASE - 32'(4 * $urandom_range(1, 4));
                else if (r == 1) a = BASE + 32'(4 * (DEPTH + $urandom_range(0, 3)));
                else a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
                a[1:0] = 2'($urandom);
                drive(p, 1'($urandom), 1'($urandom), a, 4'($urandom), $urandom);
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
